// File: rtl/lf_cfg_pkg.sv
// Shared constants for the LF SPI configuration receiver: opcodes, major modes
// and FSM state encodings.
package lf_cfg_pkg;

    localparam int unsigned OP_CONF  = 1;
    localparam int unsigned OP_DIV   = 2;
    localparam int unsigned OP_USER0 = 3;
    localparam int unsigned OP_RDSEL = 15;

    localparam logic [2:0] LF_READ     = 3'd0;
    localparam logic [2:0] LF_EDGE     = 3'd1;
    localparam logic [2:0] LF_PASSTHRU = 3'd2;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_IDLE      = 2'd1;
    localparam logic [ST_W-1:0] ST_SHIFT     = 2'd2;
    localparam logic [ST_W-1:0] ST_COMMIT    = 2'd3;

endpackage

// File: rtl/lf_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with a registered level
// and single-cycle rise/fall pulses derived from one extra history flop.
module lf_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= STAGES'({r_sync, i_d});
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level  = r_sync[STAGES-1];
    assign o_rise_c = r_sync[STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/lf_spi_cfg.sv
// SPI configuration receiver: oversamples the ARM SPI bus in the pck0 domain,
// decodes fixed-length frames into conf/divisor/user registers, reads back on miso.
module lf_spi_cfg
    import lf_cfg_pkg::*;
#(
    parameter int unsigned FRAME_W     = 16,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned CONF_W      = 9,
    parameter int unsigned N_USER      = 2,
    parameter int unsigned DIV_RESET   = 95,
    parameter logic [2:0]  ED_MODE     = LF_EDGE,
    parameter int unsigned ED_THRESH   = 127,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  pck0,
    input  logic                  rst,
    input  logic                  spck,
    input  logic                  mosi,
    input  logic                  ncs,
    output logic                  miso,
    output logic [CONF_W-1:0]     conf_word,
    output logic [2:0]            major_mode,
    output logic [7:0]            divisor,
    output logic [8*N_USER-1:0]   user_bytes,
    output logic                  cfg_strobe,
    output logic [7:0]            frame_err_cnt
);

    localparam int unsigned CNT_W = $clog2(FRAME_W + 2);
    localparam int unsigned IDX_W = (N_USER > 1) ? $clog2(N_USER) : 1;

    logic w_spck_lvl, w_spck_rise, w_spck_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;

    lf_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_spck (
        .i_clk(pck0), .i_rst(rst), .i_d(spck),
        .o_level(w_spck_lvl), .o_rise_c(w_spck_rise), .o_fall_c(w_spck_fall)
    );
    lf_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .i_clk(pck0), .i_rst(rst), .i_d(mosi),
        .o_level(w_mosi_lvl), .o_rise_c(w_mosi_rise), .o_fall_c(w_mosi_fall)
    );
    lf_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .i_clk(pck0), .i_rst(rst), .i_d(ncs),
        .o_level(w_ncs_lvl), .o_rise_c(w_ncs_rise), .o_fall_c(w_ncs_fall)
    );

    logic [ST_W-1:0]              r_state, w_state_nxt;
    logic [FRAME_W-1:0]           r_shift, w_shift_nxt;
    logic [CNT_W-1:0]             r_bitcnt, w_bitcnt_nxt;
    logic [FRAME_W-1:0]           r_rb_shift, w_rb_nxt;
    logic                         r_miso, w_miso_nxt;
    logic [CONF_W-1:0]            r_conf, w_conf_nxt;
    logic [7:0]                   r_div, w_div_nxt;
    logic [N_USER-1:0][7:0]       r_user, w_user_nxt;
    logic [3:0]                   r_rb_sel, w_rb_sel_nxt;
    logic [7:0]                   r_err, w_err_nxt;
    logic                         r_strobe, w_strobe_c;
    logic [OP_W-1:0]              w_op;
    logic [FRAME_W-1:0]           w_rb_val;
    logic                         w_unused;

    assign w_op     = r_shift[FRAME_W-1 -: OP_W];
    assign w_unused = &{w_spck_lvl, w_mosi_rise, w_mosi_fall, r_shift, 1'b0};

    // Readback source selected by the rb_sel captured in an earlier frame
    always_comb begin
        w_rb_val = '0;
        if (r_rb_sel == 4'd0) begin
            w_rb_val = FRAME_W'(r_conf);
        end else if (r_rb_sel == 4'd1) begin
            w_rb_val = FRAME_W'(r_div);
        end else begin
            for (int unsigned k = 0; k < N_USER; k++) begin
                if (r_rb_sel == 4'(2 + k)) w_rb_val = FRAME_W'(r_user[IDX_W'(k)]);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_rb_nxt     = r_rb_shift;
        w_miso_nxt   = 1'b0;
        w_conf_nxt   = r_conf;
        w_div_nxt    = r_div;
        w_user_nxt   = r_user;
        w_rb_sel_nxt = r_rb_sel;
        w_err_nxt    = r_err;
        w_strobe_c   = 1'b0;

        case (r_state)
            ST_WAIT_IDLE: begin
                if (w_ncs_lvl) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_shift_nxt  = '0;
                    w_bitcnt_nxt = '0;
                    w_rb_nxt     = w_rb_val;
                    w_miso_nxt   = w_rb_val[FRAME_W-1];
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_miso_nxt = r_miso;
                // ncs rise wins over any spck edge seen in the same cycle
                if (w_ncs_rise) begin
                    w_miso_nxt = 1'b0;
                    if (r_bitcnt == CNT_W'(FRAME_W)) begin
                        w_state_nxt = ST_COMMIT;
                    end else begin
                        if (r_err != 8'hFF) w_err_nxt = r_err + 8'd1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    if (w_spck_rise) begin
                        w_shift_nxt = {r_shift[FRAME_W-2:0], w_mosi_lvl};
                        if (r_bitcnt != CNT_W'(FRAME_W + 1)) w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
                    end
                    if (w_spck_fall) begin
                        w_rb_nxt   = r_rb_shift << 1;
                        w_miso_nxt = r_rb_shift[FRAME_W-2];
                    end
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                if (w_op == OP_W'(OP_CONF)) begin
                    w_conf_nxt = r_shift[CONF_W-1:0];
                    w_strobe_c = 1'b1;
                    if (r_shift[CONF_W-1 -: 3] == ED_MODE) w_user_nxt[0] = 8'(ED_THRESH);
                end else if (w_op == OP_W'(OP_DIV)) begin
                    w_div_nxt  = r_shift[7:0];
                    w_strobe_c = 1'b1;
                end else if (w_op == OP_W'(OP_RDSEL)) begin
                    w_rb_sel_nxt = r_shift[3:0];
                end else begin
                    for (int unsigned k = 0; k < N_USER; k++) begin
                        if (w_op == OP_W'(OP_USER0 + k)) begin
                            w_user_nxt[IDX_W'(k)] = r_shift[7:0];
                            w_strobe_c            = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            r_state    <= ST_WAIT_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_rb_shift <= '0;
            r_miso     <= 1'b0;
            r_conf     <= '0;
            r_div      <= 8'(DIV_RESET);
            r_user     <= '0;
            r_rb_sel   <= '0;
            r_err      <= '0;
            r_strobe   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_rb_shift <= w_rb_nxt;
            r_miso     <= w_miso_nxt;
            r_conf     <= w_conf_nxt;
            r_div      <= w_div_nxt;
            r_user     <= w_user_nxt;
            r_rb_sel   <= w_rb_sel_nxt;
            r_err      <= w_err_nxt;
            r_strobe   <= w_strobe_c;
        end
    end

    assign miso          = r_miso;
    assign conf_word     = r_conf;
    assign major_mode    = r_conf[CONF_W-1 -: 3];
    assign divisor       = r_div;
    assign user_bytes    = r_user;
    assign cfg_strobe    = r_strobe;
    assign frame_err_cnt = r_err;

endmodule

// File: doc/lf_spi_cfg.md
Name: lf_spi_cfg

Overview:
- Parametrised successor to the LF top-level SPI configuration receiver.
- Oversamples the ARM SPI bus (spck/mosi/ncs) in the pck0 domain and decodes fixed-length command frames into the conf word, the divisor and N user bytes.
- Adds strict frame-length checking, a per-mode default-load table, a register readback path on miso, and a commit strobe.
- Sits between the SPI pins and the mode modules and muxes.

Parameters:
- FRAME_W, 16: bits per SPI frame.
- OP_W, 4: opcode width, taken from the frame MSBs.
- CONF_W, 9: conf word width; major_mode = conf[CONF_W-1:CONF_W-3].
- N_USER, 2: number of 8-bit user registers (1..8).
- DIV_RESET, 95: divisor value after reset (125 kHz from 12 MHz/(n+1) style division).
- ED_MODE, 3'b001: major mode whose conf write reloads user0.
- ED_THRESH, 127: value loaded into user0 on an ED_MODE conf write.
- SYNC_STAGES, 2: synchroniser depth for spck, mosi and ncs.

Ports:
- pck0, in, 1: sole clock; must be >= 4x the spck frequency.
- rst, in, 1: reset, synchronous, active-high.
- spck, in, 1: SPI clock (asynchronous to pck0).
- mosi, in, 1: SPI data in, MSB first.
- ncs, in, 1: SPI chip select, active-low.
- miso, out, 1: readback data.
- conf_word, out, CONF_W: configuration register.
- major_mode, out, 3: conf_word top 3 bits.
- divisor, out, 8: clock divisor register.
- user_bytes, out, 8*N_USER: user registers; user k occupies bits [8k+7:8k].
- cfg_strobe, out, 1: one-cycle pulse when any register commits.
- frame_err_cnt, out, 8: saturating count of bad frames.

Behaviour:
- **Synchronisers and edge detect.** spck, mosi and ncs each pass SYNC_STAGES flops, then one edge-detect flop.
  - spck rise: sample mosi into shift[0], shift left, bitcnt++.
  - spck fall: advance miso.
- **FSM, WAIT_IDLE** (reset state): ignores the bus until synced ncs = 1, so no partial frame is ever accepted after reset or a mid-frame reset. Moves to IDLE.
- **FSM, IDLE:** on synced ncs falling, clear shift and bitcnt, load the readback shifter, go to SHIFT.
- **FSM, SHIFT:**
  - bitcnt saturates at FRAME_W+1.
  - On ncs rising: bitcnt == FRAME_W goes to COMMIT; otherwise frame_err_cnt++ (saturates at 255) and return to IDLE with no register change.
- **FSM, COMMIT** (one cycle), then IDLE. Decode op = shift[FRAME_W-1 -: OP_W]:
  - 1: conf_word <= shift[CONF_W-1:0]. If the new major mode == ED_MODE, also user0 <= ED_THRESH in the same cycle.
  - 2: divisor <= shift[7:0].
  - 3 .. 3+N_USER-1: user[op-3] <= shift[7:0].
  - 15: rb_sel <= shift[3:0]. rb_sel 0 = conf, 1 = divisor, 2+k = user k, others read 0. No strobe.
  - Any other op: ignored. No strobe, not an error.
- **cfg_strobe:** asserted in the COMMIT cycle for ops 1, 2 and user writes. Registers show their new value the cycle after COMMIT, the same cycle the strobe is seen registered.
- **Latency:** ncs pin rise to register update = SYNC_STAGES + 2 pck0 cycles.
- **miso:**
  - Holds the MSB of the selected register, zero-extended to FRAME_W, from frame start.
  - Shifts once per detected spck fall.
  - Drives 0 after FRAME_W bits and in IDLE.
  - The rb_sel written in frame n takes effect in frame n+1.
- **Reset values:**
  - conf_word = 0, divisor = DIV_RESET, user bytes = 0, rb_sel = 0.
  - miso = 0, cfg_strobe = 0, frame_err_cnt = 0.
  - FSM = WAIT_IDLE.
- **Simultaneous events:** an spck edge in the same synced cycle as the ncs rise is ignored (ncs has priority). rst overrides all.

Decomposition:
- Package lf_cfg_pkg holds:
  - opcode constants OP_CONF = 1, OP_DIV = 2, OP_USER0 = 3, OP_RDSEL = 15;
  - the major-mode constants (LF_READ = 0, LF_EDGE = 1, LF_PASSTHRU = 2);
  - the FSM state enum.
- One sub-module, lf_sync_edge: an N-stage synchroniser plus rise/fall pulse outputs, instantiated three times.

Test Plan:
- **Reset/defaults:** reset, no frames -> conf 0, divisor 95, user 0, miso 0, err 0, no strobe.
- **Divisor write:** frame 0x2058 -> divisor = 0x58, one strobe pulse, conf and users unchanged.
- **ED default load:** frame 0x3040 (user0 = 0x40), then frame 0x1040 (conf = 9'h040, mode 001) -> user0 = 127 and conf = 0x040 in the same cycle.
- **Short/long frames:** a 15-bit frame and a 17-bit frame -> no register change, frame_err_cnt = 2. Then 300 bad frames -> count holds at 255.
- **Readback:** write user1 = 0xA5 (frame 0x40A5), then frame 0xF003, then any 16-bit frame -> miso carries 0x00A5 MSB first, and that third frame decodes normally.
- **Mid-frame reset:** assert rst after 7 bits with ncs held low, release rst, finish the frame -> frame discarded, no strobe; the next full frame commits.
